// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-port request arbiter in front of a single-command SDRAM block
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   pN_valid/we/addr/wdata (N=0,1)   port request, held until pN_ready
//   pN_ready                         one-cycle accept pulse
//   pN_rdata/pN_rvalid               read data (held) and one-cycle update pulse
//   ram_addr/ram_wr_data             latched transaction address/data
//   ram_wr_en/ram_rd_en/ram_rd_ack   one-cycle command and acknowledge strobes
//   ram_busy/ram_rd_ready/ram_rd_data  SDRAM block status and read data
//   timeout_err                      one-cycle pulse on transaction timeout
module ram_arbiter #(
    parameter int ADDR_W    = 24,
    parameter int DATA_W    = 16,
    parameter int HOLD      = 2,
    parameter int TIMEOUT   = 255,
    parameter int FIXED_PRI = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_valid,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ready,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_rvalid,
    input  logic              p1_valid,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ready,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_rvalid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic              ram_wr_en,
    output logic              ram_rd_en,
    input  logic              ram_busy,
    input  logic              ram_rd_ready,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic              ram_rd_ack,
    output logic              timeout_err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_ACK   = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    // The counter keeps running through ACK and DRAIN, so it can pass
    // TIMEOUT by two before the DRAIN timeout check fires.
    localparam int              CNT_W  = $clog2(TIMEOUT + 3);
    localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD);
    localparam logic [CNT_W-1:0] TMO_C  = CNT_W'(TIMEOUT);

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              gnt_q, gnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              rvalid0_q, rvalid0_d;
    logic              rvalid1_q, rvalid1_d;
    logic              tmo_q, tmo_d;
    logic              gnt_sel;
    logic              hold_ok;
    logic              tmo_hit;

    // Contention goes to the port not granted last (or always port 0 in
    // fixed-priority mode); a lone requester always wins.
    always_comb begin
        if (p0_valid && p1_valid) begin
            gnt_sel = (FIXED_PRI != 0) ? 1'b0 : ~last_q;
        end else begin
            gnt_sel = p1_valid;
        end
    end

    assign hold_ok = (cnt_q >= HOLD_C);
    assign tmo_hit = (cnt_q >= TMO_C);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
        tmo_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A read still draining from before a reset also blocks grants.
                if (!ram_busy && !ram_rd_ready && (p0_valid || p1_valid)) begin
                    gnt_d   = gnt_sel;
                    last_d  = gnt_sel;
                    we_d    = gnt_sel ? p1_we    : p0_we;
                    addr_d  = gnt_sel ? p1_addr  : p0_addr;
                    wdata_d = gnt_sel ? p1_wdata : p0_wdata;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (hold_ok && we_q && !ram_busy) begin
                    state_d = S_IDLE;
                end else if (hold_ok && !we_q && ram_rd_ready) begin
                    if (gnt_q) begin
                        rdata1_d  = ram_rd_data;
                        rvalid1_d = 1'b1;
                    end else begin
                        rdata0_d  = ram_rd_data;
                        rvalid0_d = 1'b1;
                    end
                    state_d = S_ACK;
                end else if (tmo_hit) begin
                    tmo_d   = 1'b1;
                    state_d = S_IDLE;
                    // A timed-out read still completes towards the requester,
                    // with all-ones data as the poison value.
                    if (!we_q) begin
                        if (gnt_q) begin
                            rdata1_d  = '1;
                            rvalid1_d = 1'b1;
                        end else begin
                            rdata0_d  = '1;
                            rvalid0_d = 1'b1;
                        end
                    end
                end
            end
            S_ACK: begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = S_DRAIN;
            end
            S_DRAIN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!ram_rd_ready) begin
                    state_d = S_IDLE;
                end else if (tmo_hit) begin
                    tmo_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            last_q    <= 1'b1;
            gnt_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            tmo_q     <= tmo_d;
        end
    end

    // Strobes decode straight from the state register, so they are
    // mutually exclusive by construction and last exactly one cycle.
    assign p0_ready    = (state_q == S_ISSUE) && !gnt_q;
    assign p1_ready    = (state_q == S_ISSUE) &&  gnt_q;
    assign ram_wr_en   = (state_q == S_ISSUE) &&  we_q;
    assign ram_rd_en   = (state_q == S_ISSUE) && !we_q;
    assign ram_rd_ack  = (state_q == S_ACK);
    assign ram_addr    = addr_q;
    assign ram_wr_data = wdata_q;
    assign p0_rdata    = rdata0_q;
    assign p1_rdata    = rdata1_q;
    assign p0_rvalid   = rvalid0_q;
    assign p1_rvalid   = rvalid1_q;
    assign timeout_err = tmo_q;

endmodule
